multi_cycle_cpu: RTL and testbench



---
 rtl/mcpu_pkg.sv | 51 +++++
 rtl/regfile_param.sv | 32 +++
 rtl/multi_cycle_cpu.sv | 162 ++++++++++++++++
 tb/tb_multi_cycle_cpu.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle 16-bit-instruction core:
// opcodes, ALU control encodings and FSM state encoding.
package mcpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_HALT = 4'b1111;

    typedef enum logic [3:0] {
        ALU_AND  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_NOR  = 4'b1100,
        ALU_NAND = 4'b1101
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    // Everything that is not an explicit R-type op uses the adder (addi, lw/sw address).
    function automatic alu_ctrl_e alu_ctrl_for(input logic [3:0] op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_NOR:  return ALU_NOR;
            OP_NAND: return ALU_NAND;
            OP_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/regfile_param.sv
// Four-entry register file: two asynchronous read ports, one synchronous
// write port, r0 hardwired to zero.
module regfile_param #(
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        ra1,
    input  logic [1:0]        ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [1:0]        wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [1:3];

    // NOTE: this array is small and must read as zero after reset, so it is
    // cleared explicitly; larger memories would normally be left unreset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 1; i < 4; i++) regs[i] <= '0;
        end else if (we && wa != 2'd0) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 2'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 2'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/multi_cycle_cpu.sv
// Multi-cycle core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with
// req/ack handshakes to external instruction and data memories.
module multi_cycle_cpu
    import mcpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc,
    output logic              retire,
    output logic [DATA_W-1:0] wb_data,
    output logic              halted
);

    state_e            state, state_nx;
    logic [15:0]       ir;
    logic [ADDR_W-1:0] pc_q, br_off;
    logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
    logic [DATA_W-1:0] rd1, rd2, imm_sx, opb, alu_res, rf_wd;
    logic [3:0]        op;
    logic [1:0]        rf_wa;
    logic              is_rtype, is_mem, is_branch, is_nop, br_taken, rf_we;
    alu_ctrl_e         alu_ctrl;

    assign op        = ir[15:12];
    assign is_rtype  = (op <= OP_SLT);
    assign is_mem    = (op == OP_LW) || (op == OP_SW);
    assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
    assign is_nop    = (op == 4'hC) || (op == 4'hD) || (op == 4'hE);
    assign imm_sx    = {{(DATA_W-8){ir[7]}}, ir[7:0]};
    assign br_off    = {{(ADDR_W-9){ir[7]}}, ir[7:0], 1'b0};
    assign br_taken  = (op == OP_BEQ) == (a_q == b_q);
    assign opb       = ((op == OP_ADDI) || is_mem) ? imm_sx : b_q;
    assign alu_ctrl  = alu_ctrl_for(op);

    always_comb begin
        alu_res = '0;
        case (alu_ctrl)
            ALU_AND:  alu_res = a_q & opb;
            ALU_OR:   alu_res = a_q | opb;
            ALU_SUB:  alu_res = a_q - opb;
            ALU_SLT:  alu_res = DATA_W'($signed(a_q) < $signed(opb));
            ALU_NOR:  alu_res = ~(a_q | opb);
            ALU_NAND: alu_res = ~(a_q & opb);
            default:  alu_res = a_q + opb;
        endcase
    end

    // R-types write rd; addi and lw write rt.
    assign rf_we = (state == S_WB);
    assign rf_wa = is_rtype ? ir[7:6] : ir[9:8];
    assign rf_wd = (op == OP_LW) ? mdr_q : alu_q;

    regfile_param #(.DATA_W(DATA_W)) u_regfile (
        .clock (clock),
        .reset (reset),
        .ra1   (ir[11:10]),
        .ra2   (ir[9:8]),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nx = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HALT) state_nx = S_HALT;
                else if (is_nop)   state_nx = S_FETCH;
                else               state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (is_mem)         state_nx = S_MEM;
                else if (is_branch) state_nx = S_FETCH;
                else                state_nx = S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_nx = (op == OP_LW) ? S_WB : S_FETCH;
            end
            S_WB:    state_nx = S_FETCH;
            S_HALT:  state_nx = S_HALT;
            default: state_nx = S_FETCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_FETCH;
            ir      <= '0;
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            wb_data <= '0;
            retire  <= 1'b0;
        end else begin
            state  <= state_nx;
            retire <= 1'b0;
            case (state)
                S_FETCH: if (imem_ack) begin
                    ir   <= imem_rdata;
                    pc_q <= pc_q + ADDR_W'(2);
                end
                S_DECODE: begin
                    a_q    <= rd1;
                    b_q    <= rd2;
                    retire <= is_nop;
                end
                S_EXEC: begin
                    alu_q <= alu_res;
                    if (is_branch) begin
                        retire <= 1'b1;
                        if (br_taken) pc_q <= pc_q + br_off;
                    end
                end
                S_MEM: if (dmem_ack) begin
                    mdr_q  <= dmem_rdata;
                    retire <= (op == OP_SW);
                end
                S_WB: begin
                    wb_data <= rf_wd;
                    retire  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pc         = pc_q;
    assign imem_addr  = pc_q;
    assign dmem_we    = (op == OP_SW);
    assign dmem_addr  = alu_q[ADDR_W-1:0];
    assign dmem_wdata = b_q;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_multi_cycle_cpu.sv
// Scoreboard bench for multi_cycle_cpu: an instruction-level model fills
// expectation queues; a monitor and memory responders compare DUT activity.
module tb_multi_cycle_cpu;
    import mcpu_pkg::*;

    localparam int DW = 32;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          imem_req, imem_ack;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_rdata;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata, dmem_rdata;
    logic [AW-1:0] pc;
    logic          retire, halted;
    logic [DW-1:0] wb_data;

    multi_cycle_cpu #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .pc(pc), .retire(retire), .wb_data(wb_data), .halted(halted)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] wb;
        logic [AW-1:0] pc;
        int            lat;
    } exp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } st_t;

    exp_t          exp_q[$];
    st_t           st_q[$];
    logic [DW-1:0] obs_wb[$];
    logic [AW-1:0] obs_pc[$];
    logic [15:0]   prog[$];
    logic [15:0]   imem_mem [0:(1<<(AW-1))-1];
    logic [DW-1:0] dmem_mem [logic [AW-1:0]];

    int n_checks = 0;
    int n_errors = 0;
    int iw = 0, dw = 0, m_halt_lat = 0;
    bit spur = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] r_ins(input logic [3:0] op, input logic [1:0] rs,
                                          input logic [1:0] rt, input logic [1:0] rd);
        return {op, rs, rt, rd, 6'b0};
    endfunction

    function automatic logic [15:0] i_ins(input logic [3:0] op, input logic [1:0] rs,
                                          input logic [1:0] rt, input logic [7:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Instruction-level reference: executes the program architecturally and
    // records what each retirement must look like and how long it takes.
    task automatic model_run();
        logic [DW-1:0]        r [4];
        logic [DW-1:0]        mdm [logic [AW-1:0]];
        logic [AW-1:0]        mpc, npc, addr;
        logic [DW-1:0]        a, b, res, wb;
        logic signed [DW-1:0] simm;
        logic signed [7:0]    imm8;
        logic [15:0]          ins;
        logic [3:0]           op;
        int                   dst, lat;
        bit                   done;
        exp_t                 e;
        st_t                  s;
        for (int i = 0; i < 4; i++) r[i] = '0;
        mpc = '0; wb = '0; done = 1'b0;
        for (int n = 0; n < 2000 && !done; n++) begin
            ins  = imem_mem[mpc[AW-1:1]];
            op   = ins[15:12];
            a    = r[ins[11:10]];
            b    = r[ins[9:8]];
            imm8 = ins[7:0];
            simm = imm8;
            npc  = mpc + 16'd2;
            dst  = -1;
            res  = '0;
            lat  = 4 + iw;
            case (op)
                OP_ADD:  begin res = a + b;     dst = int'(ins[7:6]); end
                OP_SUB:  begin res = a - b;     dst = int'(ins[7:6]); end
                OP_AND:  begin res = a & b;     dst = int'(ins[7:6]); end
                OP_OR:   begin res = a | b;     dst = int'(ins[7:6]); end
                OP_NOR:  begin res = ~(a | b);  dst = int'(ins[7:6]); end
                OP_NAND: begin res = ~(a & b);  dst = int'(ins[7:6]); end
                OP_SLT:  begin res[0] = ($signed(a) < $signed(b)); dst = int'(ins[7:6]); end
                OP_ADDI: begin res = a + DW'(simm); dst = int'(ins[9:8]); end
                OP_LW: begin
                    addr = AW'(a + DW'(simm));
                    res  = mdm.exists(addr) ? mdm[addr] : '0;
                    dst  = int'(ins[9:8]);
                    lat  = 5 + iw + dw;
                end
                OP_SW: begin
                    addr = AW'(a + DW'(simm));
                    mdm[addr] = b;
                    s.addr = addr; s.data = b;
                    st_q.push_back(s);
                    lat = 4 + iw + dw;
                end
                OP_BEQ, OP_BNE: begin
                    if ((a == b) == (op == OP_BEQ)) npc = npc + AW'(simm * 2);
                    lat = 3 + iw;
                end
                OP_HALT: begin done = 1'b1; m_halt_lat = 2 + iw; end
                default: lat = 2 + iw;
            endcase
            if (dst >= 0) begin
                if (dst != 0) r[dst] = res;
                wb = res;
            end
            if (!done) begin
                e.wb = wb; e.pc = npc; e.lat = lat;
                exp_q.push_back(e);
            end
            mpc = npc;
        end
    endtask

    // Retirement monitor.
    int cyc, last;
    bit halt_seen;
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset) begin
                cyc = 0; last = 1; halt_seen = 1'b0;
            end else begin
                cyc++;
                if (retire) begin
                    check("retire_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        obs_wb.push_back(wb_data);
                        obs_pc.push_back(pc);
                        check("wb_data", wb_data, e.wb);
                        check("pc_after_retire", pc, e.pc);
                        check("latency", 64'(cyc - last), 64'(e.lat));
                    end
                    last = cyc;
                end
                if (halted && !halt_seen) begin
                    halt_seen = 1'b1;
                    check("halt_latency", 64'(cyc - last), 64'(m_halt_lat));
                end
            end
        end
    end

    // Memory responders with programmable wait states and stray acks while idle.
    int            i_cnt, d_cnt;
    bit            i_busy, d_busy;
    logic [AW-1:0] i_hold, d_hold;
    logic [DW-1:0] d_hold_wd;
    logic          d_hold_we;
    initial begin
        st_t s;
        imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                imem_ack = 1'b0; dmem_ack = 1'b0;
                i_cnt = 0; d_cnt = 0; i_busy = 1'b0; d_busy = 1'b0;
            end else begin
                if (imem_req) begin
                    if (!i_busy) begin i_busy = 1'b1; i_hold = imem_addr; end
                    else check("imem_addr_stable", imem_addr, i_hold);
                    if (i_cnt < iw) begin
                        imem_ack = 1'b0; imem_rdata = 16'($urandom); i_cnt++;
                    end else begin
                        imem_ack = 1'b1; imem_rdata = imem_mem[imem_addr[AW-1:1]];
                        i_cnt = 0; i_busy = 1'b0;
                    end
                end else begin
                    imem_ack   = spur ? 1'($urandom) : 1'b0;
                    imem_rdata = 16'($urandom);
                end
                if (dmem_req) begin
                    if (!d_busy) begin
                        d_busy = 1'b1; d_hold = dmem_addr; d_hold_wd = dmem_wdata; d_hold_we = dmem_we;
                    end else begin
                        check("dmem_addr_stable", dmem_addr, d_hold);
                        check("dmem_wdata_stable", dmem_wdata, d_hold_wd);
                        check("dmem_we_stable", dmem_we, d_hold_we);
                    end
                    if (d_cnt < dw) begin
                        dmem_ack = 1'b0; dmem_rdata = DW'($urandom); d_cnt++;
                    end else begin
                        dmem_ack = 1'b1; d_cnt = 0; d_busy = 1'b0;
                        if (dmem_we) begin
                            dmem_mem[dmem_addr] = dmem_wdata;
                            check("store_expected", 64'(st_q.size() != 0), 64'd1);
                            if (st_q.size() != 0) begin
                                s = st_q.pop_front();
                                check("store_addr", dmem_addr, s.addr);
                                check("store_data", dmem_wdata, s.data);
                            end
                        end else begin
                            dmem_rdata = dmem_mem.exists(dmem_addr) ? dmem_mem[dmem_addr] : '0;
                        end
                    end
                end else begin
                    dmem_ack   = spur ? 1'($urandom) : 1'b0;
                    dmem_rdata = DW'($urandom);
                end
            end
        end
    end

    task automatic load_and_reset();
        @(posedge clock); #1 reset = 1'b1;
        foreach (imem_mem[i]) imem_mem[i] = 16'hF000;
        foreach (prog[i]) imem_mem[i] = prog[i];
        dmem_mem.delete(); exp_q.delete(); st_q.delete(); obs_wb.delete(); obs_pc.delete();
        model_run();
        @(posedge clock); #1;
        check("rst_pc", pc, 0);
        check("rst_retire", retire, 0);
        check("rst_halted", halted, 0);
        check("rst_dmem_req", dmem_req, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_imem_req", imem_req, 1);
    endtask

    task automatic run_to_halt();
        int i;
        reset = 1'b0;
        i = 0;
        while (!halted && i < 4000) begin @(posedge clock); #1; i++; end
        check("halt_reached", halted, 1);
        repeat (10) @(posedge clock);
        #1;
        check("retire_queue_drained", 64'(exp_q.size()), 0);
        check("store_queue_drained", 64'(st_q.size()), 0);
        check("imem_req_after_halt", imem_req, 0);
        check("halted_stays", halted, 1);
    endtask

    logic [DW-1:0] spec_wb [9];

    initial begin
        spec_wb = '{32'd15, 32'd7, 32'd7, 32'd8, 32'd15, 32'd22, 32'hFFFF_FFE0, 32'd0, 32'd1};

        // ALU program, zero-wait memories.
        iw = 0; dw = 0; spur = 1'b0;
        prog = '{i_ins(OP_ADDI, 0, 1, 8'd15), i_ins(OP_ADDI, 0, 2, 8'd7),
                 r_ins(OP_AND, 1, 2, 3), r_ins(OP_SUB, 1, 3, 2), r_ins(OP_OR, 2, 3, 2),
                 r_ins(OP_ADD, 2, 3, 3), r_ins(OP_NOR, 2, 3, 1), r_ins(OP_SLT, 3, 2, 1),
                 r_ins(OP_SLT, 2, 3, 1), 16'hF000};
        load_and_reset();
        run_to_halt();
        check("alu_prog_retires", 64'(obs_wb.size()), 9);
        for (int i = 0; i < 9 && i < obs_wb.size(); i++) check("alu_prog_wb", obs_wb[i], spec_wb[i]);

        // Store/load of all-ones, zero-wait then with wait states and stray acks.
        prog = '{i_ins(OP_ADDI, 0, 1, 8'hFF), i_ins(OP_SW, 0, 1, 8'd4),
                 i_ins(OP_LW, 0, 2, 8'd4), 16'hF000};
        for (int pass = 0; pass < 2; pass++) begin
            iw = pass * 3; dw = pass * 2; spur = (pass == 1);
            load_and_reset();
            run_to_halt();
            check("mem_prog_final_wb", wb_data, 32'hFFFF_FFFF);
            check("mem_word4", dmem_mem.exists(16'd4) ? dmem_mem[16'd4] : '0, 32'hFFFF_FFFF);
        end

        // Branches: beq taken, bne not taken, backward beq to address 0.
        iw = 0; dw = 0; spur = 1'b1;
        prog = '{i_ins(OP_ADDI, 0, 1, 8'd5), i_ins(OP_ADDI, 0, 2, 8'd5), 16'hC000, 16'hD000,
                 i_ins(OP_BEQ, 1, 2, 8'd2), i_ins(OP_ADDI, 0, 3, 8'd1), i_ins(OP_ADDI, 0, 3, 8'd2),
                 16'hF000};
        load_and_reset();
        run_to_halt();
        check("beq_target", obs_pc.size() > 4 ? obs_pc[4] : '1, 16'd14);
        prog[4] = i_ins(OP_BNE, 1, 2, 8'd2);
        prog[5] = 16'hF000;
        load_and_reset();
        run_to_halt();
        check("bne_fallthrough", obs_pc.size() > 4 ? obs_pc[4] : '1, 16'd10);
        prog = '{i_ins(OP_ADDI, 3, 3, 8'd1), i_ins(OP_ADDI, 0, 1, 8'd1), 16'hC000, 16'hE000,
                 i_ins(OP_BEQ, 3, 1, 8'hFB), 16'hF000};
        load_and_reset();
        run_to_halt();
        check("beq_back_to_zero", obs_pc.size() > 4 ? obs_pc[4] : '1, 16'd0);

        // Writes to r0 are discarded.
        prog = '{i_ins(OP_ADDI, 0, 0, 8'd9), r_ins(OP_ADD, 0, 0, 1), 16'hF000};
        load_and_reset();
        run_to_halt();
        check("r0_stays_zero", obs_wb.size() > 1 ? obs_wb[1] : '1, 0);

        // Reset while a store waits in MEM.
        iw = 0; dw = 30; spur = 1'b1;
        prog = '{i_ins(OP_ADDI, 0, 1, 8'd3), i_ins(OP_ADDI, 0, 2, 8'd4),
                 i_ins(OP_SW, 0, 1, 8'd8), 16'hF000};
        load_and_reset();
        reset = 1'b0;
        for (int i = 0; i < 100 && !dmem_req; i++) begin @(posedge clock); #1; end
        check("reached_mem", dmem_req, 1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        check("midrst_dmem_req", dmem_req, 0);
        check("midrst_pc", pc, 0);
        check("midrst_retire", retire, 0);
        check("midrst_no_store", dmem_mem.exists(16'd8), 0);
        dw = 0;
        prog = '{r_ins(OP_ADD, 1, 2, 3), i_ins(OP_SW, 0, 1, 8'd8), 16'hF000};
        load_and_reset();
        run_to_halt();
        check("midrst_regs_cleared", obs_wb.size() > 0 ? obs_wb[0] : '1, 0);

        // Randomised programs with forward-only branches.
        for (int t = 0; t < 4; t++) begin
            logic [3:0] op;
            logic [7:0] imm;
            iw = $urandom_range(0, 2); dw = $urandom_range(0, 2); spur = 1'b1;
            prog.delete();
            for (int i = 0; i < 40; i++) begin
                op  = 4'($urandom_range(0, 14));
                imm = 8'($urandom);
                if (op == OP_BEQ || op == OP_BNE) imm = 8'($urandom_range(0, 3));
                if (op <= OP_SLT) imm = {2'($urandom), 6'b0};
                prog.push_back({op, 2'($urandom), 2'($urandom), imm});
            end
            prog.push_back(16'hF000);
            load_and_reset();
            run_to_halt();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #(600_000);
        $display("FAIL watchdog_timeout actual=%0t expected=<600000", $time);
        $fatal(1);
    end

endmodule
